ma_pipeline: RTL and testbench

//  Memory-access stage, directly downstream of the execute stage's EX/MA register.

---
 rtl/ma_pipeline_if.sv | 31 +++
 rtl/ma_pipeline.sv | 231 +++++++++++++++++++++++
 tb/tb_ma_pipeline.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ma_pipeline_if.sv
// Data-memory bus between the memory-access stage and data memory.
// The stage drives the request side; memory returns rdata/ready.
interface ma_pipeline_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/ma_pipeline.sv
// Memory-access pipeline stage: issues loads/stores over a req/ready
// handshake, aligns store data, extends load data, stalls the front end on
// wait states, aborts on misalignment/illegal funct3/timeout, and holds the
// MA/WB register feeding write-back.
module ma_pipeline #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWEn_in,
  input  logic        MemRW_in,
  input  logic [1:0]  WBSel_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] DataB_in,
  input  logic [31:0] pcPlus4_in,
  input  logic [4:0]  AddrD_in,
  ma_pipeline_if.master dmem,
  output logic        ma_stall,
  output logic        access_fault,
  output logic        RegWEn_out,
  output logic [1:0]  WBSel_out,
  output logic [4:0]  AddrD_out,
  output logic [31:0] ALU_Result_out,
  output logic [31:0] MemData_out,
  output logic [31:0] pcPlus4_out
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          regwen_q, regwen_d;
  logic [1:0]    wbsel_q, wbsel_d;
  logic [4:0]    addrd_q, addrd_d;
  logic [31:0]   alu_q, alu_d;
  logic [31:0]   mem_q, mem_d;
  logic [31:0]   pc4_q, pc4_d;

  logic          is_load, is_store, mem_op;
  logic          bad_f3, misaligned, bad_op;
  logic          req, fault, capture, take;
  logic [1:0]    a_lo;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign a_lo = ALU_Result_in[1:0];

  // Classify the EX/MA operation and detect accesses that must not be issued.
  always_comb begin
    is_store   = MemRW_in;
    is_load    = RegWEn_in && (WBSel_in == 2'b00) && !MemRW_in;
    mem_op     = is_store || is_load;
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      bad_f3 = funct3_in[2] || (funct3_in[1:0] == 2'b11);
    end else begin
      bad_f3 = (funct3_in == 3'b011) || (funct3_in == 3'b110) || (funct3_in == 3'b111);
    end
    case (funct3_in[1:0])
      2'b01:   misaligned = a_lo[0];
      2'b10:   misaligned = (a_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    bad_op = mem_op && (bad_f3 || misaligned);
  end

  // Lane-align store data and byte enables according to access size.
  always_comb begin
    be    = '0;
    wdata = DataB_in;
    case (funct3_in[1:0])
      2'b00: begin
        be    = 4'b0001 << a_lo;
        wdata = {4{DataB_in[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << a_lo;
        wdata = {2{DataB_in[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = DataB_in;
      end
      default: begin
        be    = '0;
        wdata = DataB_in;
      end
    endcase
  end

  // Select the addressed byte/half of the returned word and extend it.
  always_comb begin
    case (a_lo)
      2'b00:   ld_byte = dmem.dmem_rdata[7:0];
      2'b01:   ld_byte = dmem.dmem_rdata[15:8];
      2'b10:   ld_byte = dmem.dmem_rdata[23:16];
      default: ld_byte = dmem.dmem_rdata[31:24];
    endcase
    ld_half = a_lo[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_in)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = dmem.dmem_rdata;
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = '0;
    endcase
  end

  // Handshake FSM: issue, wait for ready, abort after TIMEOUT request cycles.
  // The timeout cycle itself drops req and releases the stall so the aborted
  // instruction leaves as a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    fault   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bad_op) begin
          fault = 1'b1;
        end else if (mem_op) begin
          req = 1'b1;
          if (dmem.dmem_ready) begin
            capture = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == CW'(TIMEOUT)) begin
          fault   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          req = 1'b1;
          if (dmem.dmem_ready) begin
            capture = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign take = capture || ((state_q == IDLE) && !mem_op);

  // MA/WB next state: load on completion or pass-through, otherwise bubble.
  always_comb begin
    regwen_d = 1'b0;
    wbsel_d  = wbsel_q;
    addrd_d  = addrd_q;
    alu_d    = alu_q;
    mem_d    = mem_q;
    pc4_d    = pc4_q;
    if (take) begin
      regwen_d = RegWEn_in;
      wbsel_d  = WBSel_in;
      addrd_d  = AddrD_in;
      alu_d    = ALU_Result_in;
      mem_d    = (capture && is_load) ? ld_ext : '0;
      pc4_d    = pcPlus4_in;
    end
  end

  // FSM and wait counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MA/WB pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwen_q <= 1'b0;
      wbsel_q  <= '0;
      addrd_q  <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      pc4_q    <= '0;
    end else begin
      regwen_q <= regwen_d;
      wbsel_q  <= wbsel_d;
      addrd_q  <= addrd_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      pc4_q    <= pc4_d;
    end
  end

  assign dmem.dmem_req   = reset_n && req;
  assign dmem.dmem_we    = reset_n && req && is_store;
  assign dmem.dmem_addr  = {ALU_Result_in[31:2], 2'b00};
  assign dmem.dmem_be    = be;
  assign dmem.dmem_wdata = wdata;

  assign ma_stall     = reset_n && req && !dmem.dmem_ready;
  assign access_fault = reset_n && fault;

  assign RegWEn_out     = regwen_q;
  assign WBSel_out      = wbsel_q;
  assign AddrD_out      = addrd_q;
  assign ALU_Result_out = alu_q;
  assign MemData_out    = mem_q;
  assign pcPlus4_out    = pc4_q;

endmodule

// File: tb/tb_ma_pipeline.sv
// Bench for ma_pipeline: directed scenarios followed by random instructions,
// checked cycle by cycle against a transaction-level reference model.
module tb_ma_pipeline;
  localparam int unsigned TO = 16;

  logic        clk;
  logic        reset_n;
  logic        RegWEn_in;
  logic        MemRW_in;
  logic [1:0]  WBSel_in;
  logic [2:0]  funct3_in;
  logic [31:0] ALU_Result_in;
  logic [31:0] DataB_in;
  logic [31:0] pcPlus4_in;
  logic [4:0]  AddrD_in;
  logic        ma_stall;
  logic        access_fault;
  logic        RegWEn_out;
  logic [1:0]  WBSel_out;
  logic [4:0]  AddrD_out;
  logic [31:0] ALU_Result_out;
  logic [31:0] MemData_out;
  logic [31:0] pcPlus4_out;

  ma_pipeline_if bus ();

  ma_pipeline #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .RegWEn_in      (RegWEn_in),
    .MemRW_in       (MemRW_in),
    .WBSel_in       (WBSel_in),
    .funct3_in      (funct3_in),
    .ALU_Result_in  (ALU_Result_in),
    .DataB_in       (DataB_in),
    .pcPlus4_in     (pcPlus4_in),
    .AddrD_in       (AddrD_in),
    .dmem           (bus),
    .ma_stall       (ma_stall),
    .access_fault   (access_fault),
    .RegWEn_out     (RegWEn_out),
    .WBSel_out      (WBSel_out),
    .AddrD_out      (AddrD_out),
    .ALU_Result_out (ALU_Result_out),
    .MemData_out    (MemData_out),
    .pcPlus4_out    (pcPlus4_out)
  );

  int checks;
  int failures;

  // expected MA/WB contents
  logic        m_rwe;
  logic [1:0]  m_wbs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu;
  logic [31:0] m_mem;
  logic [31:0] m_pc4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_regs();
    chk("RegWEn_out", {31'd0, RegWEn_out}, {31'd0, m_rwe});
    chk("WBSel_out", {30'd0, WBSel_out}, {30'd0, m_wbs});
    chk("AddrD_out", {27'd0, AddrD_out}, {27'd0, m_rd});
    chk("ALU_Result_out", ALU_Result_out, m_alu);
    chk("MemData_out", MemData_out, m_mem);
    chk("pcPlus4_out", pcPlus4_out, m_pc4);
  endtask

  function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int unsigned size;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = 1 << f3[1:0];
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd2:    return rd;
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // Apply one instruction at posedge+1 and follow it until it leaves the
  // stage. Memory answers with rdat when k == lat (lat >= TO: never in time).
  task automatic do_instr(input logic rwe, input logic mrw, input logic [1:0] wbs,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] db,
                          input logic [31:0] pc4, input logic [4:0] rd,
                          input int unsigned lat, input logic [31:0] rdat);
    bit          ld, st, flt, done;
    int unsigned sz;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    logic [31:0] rdv;
    st = mrw;
    ld = rwe && (wbs == 2'b00) && !mrw;
    RegWEn_in = rwe; MemRW_in = mrw; WBSel_in = wbs; funct3_in = f3;
    ALU_Result_in = alu; DataB_in = db; pcPlus4_in = pc4; AddrD_in = rd;
    flt  = (st || ld) && ref_fault(st, f3, alu);
    sz   = 1 << f3[1:0];
    be_e = 4'(((1 << sz) - 1) << alu[1:0]);
    wd_e = (sz == 1) ? {4{db[7:0]}} : (sz == 2) ? {2{db[15:0]}} : db;
    done = 1'b0;
    for (int unsigned k = 0; k <= TO && !done; k++) begin
      rdv = (k == lat) ? rdat : $urandom;
      bus.dmem_rdata = rdv;
      if (st || ld) bus.dmem_ready = (k == lat);
      else          bus.dmem_ready = 1'($urandom_range(0, 1));
      #3;
      if (!(st || ld) || flt || k == TO) begin
        chk("dmem_req_off", {31'd0, bus.dmem_req}, 32'd0);
        chk("ma_stall_off", {31'd0, ma_stall}, 32'd0);
        chk("access_fault", {31'd0, access_fault}, {31'd0, (st || ld)});
      end else begin
        chk("dmem_req_on", {31'd0, bus.dmem_req}, 32'd1);
        chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, st});
        chk("dmem_addr", bus.dmem_addr, alu & 32'hFFFF_FFFC);
        chk("ma_stall", {31'd0, ma_stall}, {31'd0, (k != lat)});
        chk("access_fault_off", {31'd0, access_fault}, 32'd0);
        if (st) begin
          chk("dmem_be", {28'd0, bus.dmem_be}, {28'd0, be_e});
          chk("dmem_wdata", bus.dmem_wdata, wd_e);
        end
      end
      @(posedge clk);
      #1;
      if (!(st || ld) || ((k == lat) && !flt && k < TO)) begin
        m_rwe = rwe; m_wbs = wbs; m_rd = rd; m_alu = alu; m_pc4 = pc4;
        m_mem = ld ? ref_load(f3, alu, rdv) : 32'd0;
        done  = 1'b1;
      end else begin
        m_rwe = 1'b0;
        if (flt || k == TO) done = 1'b1;
      end
      check_regs();
    end
  endtask

  initial begin
    int unsigned lat, r, kind;
    logic        rwe, mrw;
    logic [1:0]  wbs;
    logic [2:0]  f3;
    logic [31:0] a;

    checks = 0; failures = 0;
    reset_n = 1'b0;
    RegWEn_in = 1'b0; MemRW_in = 1'b0; WBSel_in = 2'b01; funct3_in = 3'd0;
    ALU_Result_in = '0; DataB_in = '0; pcPlus4_in = '0; AddrD_in = '0;
    bus.dmem_rdata = '0; bus.dmem_ready = 1'b0;
    m_rwe = 1'b0; m_wbs = '0; m_rd = '0; m_alu = '0; m_mem = '0; m_pc4 = '0;

    #2;
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, ma_stall}, 32'd0);
    chk("rst_fault", {31'd0, access_fault}, 32'd0);
    check_regs();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ALU pass-through
    do_instr(1'b1, 1'b0, 2'b01, 3'd0, 32'h0000_1234, 32'h5555_AAAA, 32'h0000_0104, 5'd5, 0, 32'd0);
    chk("alu_regwen", {31'd0, RegWEn_out}, 32'd1);
    chk("alu_result", ALU_Result_out, 32'h0000_1234);
    // SB into top lane, memory ready immediately
    do_instr(1'b0, 1'b1, 2'b00, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h108, 5'd0, 0, 32'd0);
    // LB with three wait states
    do_instr(1'b1, 1'b0, 2'b00, 3'd0, 32'h0000_2001, 32'd0, 32'h10C, 5'd7, 3, 32'h0000_8000);
    chk("lb_memdata", MemData_out, 32'hFFFF_FF80);
    // misaligned LW
    do_instr(1'b1, 1'b0, 2'b00, 3'd2, 32'h0000_2002, 32'd0, 32'h110, 5'd8, 0, 32'd0);
    // load that never completes
    do_instr(1'b1, 1'b0, 2'b00, 3'd2, 32'h0000_3000, 32'd0, 32'h114, 5'd9, 1000, 32'd0);
    // ready arrives in the last allowed request cycle, then one cycle too late
    do_instr(1'b1, 1'b0, 2'b00, 3'd5, 32'h0000_3002, 32'd0, 32'h118, 5'd10, TO - 1, 32'hBEEF_1234);
    do_instr(1'b1, 1'b0, 2'b00, 3'd4, 32'h0000_3003, 32'd0, 32'h11C, 5'd11, TO, 32'h8123_4567);
    // SH upper half, LHU, illegal store funct3, LH misaligned
    do_instr(1'b0, 1'b1, 2'b00, 3'd1, 32'h0000_4002, 32'h1234_CDEF, 32'h120, 5'd0, 1, 32'd0);
    do_instr(1'b1, 1'b0, 2'b00, 3'd5, 32'h0000_4002, 32'd0, 32'h124, 5'd12, 0, 32'hF00D_0000);
    do_instr(1'b0, 1'b1, 2'b01, 3'd4, 32'h0000_4000, 32'hFFFF_FFFF, 32'h128, 5'd0, 0, 32'd0);
    do_instr(1'b1, 1'b0, 2'b00, 3'd1, 32'h0000_4001, 32'd0, 32'h12C, 5'd13, 0, 32'd0);

    // asynchronous reset in the middle of a wait
    do_instr(1'b1, 1'b0, 2'b10, 3'd0, 32'h0000_5678, 32'd0, 32'h130, 5'd14, 0, 32'd0);
    RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = 2'b00; funct3_in = 3'd2;
    ALU_Result_in = 32'h0000_6000; AddrD_in = 5'd15; bus.dmem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("busy_stall", {31'd0, ma_stall}, 32'd1);
    m_rwe = 1'b0;
    check_regs();
    #2;
    reset_n = 1'b0;
    #1;
    m_rwe = 1'b0; m_wbs = '0; m_rd = '0; m_alu = '0; m_mem = '0; m_pc4 = '0;
    chk("midrst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("midrst_stall", {31'd0, ma_stall}, 32'd0);
    chk("midrst_fault", {31'd0, access_fault}, 32'd0);
    check_regs();
    RegWEn_in = 1'b0; WBSel_in = 2'b01;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // random instruction stream
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom & 32'h0000_FFFF;
      r    = $urandom_range(0, 9);
      lat  = (r < 6) ? (r % 4) : (r < 8) ? TO - 1 : (r == 8) ? TO : 1000;
      if (kind == 0) begin
        rwe = 1'($urandom_range(0, 1)); mrw = 1'b0;
        wbs = rwe ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      end else if (kind == 1) begin
        rwe = 1'b1; mrw = 1'b0; wbs = 2'b00;
      end else begin
        rwe = 1'b0; mrw = 1'b1; wbs = 2'($urandom_range(0, 3));
      end
      do_instr(rwe, mrw, wbs, f3, a, $urandom, $urandom, 5'($urandom_range(0, 31)), lat, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
